// File: rtl/fp_normalize_pipe_if.sv
// Handshake and data bundle for the FP normalisation stage.
// Lane i of every bus occupies slice [i*width +: width].
interface fp_normalize_pipe_if #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10,
  parameter int LANES    = 1,
  parameter int TAG_W    = 4
);
  localparam int SW = MANTISSA + EXPONENT + 2;

  logic                            in_valid;
  logic                            in_ready;
  logic [LANES*SW-1:0]             in_sum;
  logic [LANES*EXPONENT-1:0]       in_cexp;
  logic [TAG_W-1:0]                in_tag;
  logic                            out_valid;
  logic                            out_ready;
  logic [LANES*MANTISSA-1:0]       out_normm;
  logic [LANES*(EXPONENT+1)-1:0]   out_norme;
  logic [LANES-1:0]                out_zero, out_nege, out_ovf, out_fg, out_r, out_s;
  logic [TAG_W-1:0]                out_tag;

  modport master (
    output in_valid, in_sum, in_cexp, in_tag, out_ready,
    input  in_ready, out_valid, out_normm, out_norme, out_zero, out_nege,
           out_ovf, out_fg, out_r, out_s, out_tag
  );

  modport slave (
    input  in_valid, in_sum, in_cexp, in_tag, out_ready,
    output in_ready, out_valid, out_normm, out_norme, out_zero, out_nege,
           out_ovf, out_fg, out_r, out_s, out_tag
  );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage multi-lane normaliser: S1 registers the sum and its leading-zero
// count, S2 shifts, adjusts the exponent and extracts FG/R/S for rounding.
module fp_normalize_lane #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10,
  parameter int SW       = MANTISSA + EXPONENT + 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ld1,
  input  logic                ld2,
  input  logic [SW-1:0]       sum_i,
  input  logic [EXPONENT-1:0] cexp_i,
  output logic [MANTISSA-1:0] normm_o,
  output logic [EXPONENT:0]   norme_o,
  output logic                zero_o,
  output logic                nege_o,
  output logic                ovf_o,
  output logic                fg_o,
  output logic                r_o,
  output logic                s_o
);
  localparam int EW  = EXPONENT + 1;
  localparam int LZW = $clog2(SW);

  logic [SW-1:0]       sum_q, sum_d;
  logic [EXPONENT-1:0] cexp_q, cexp_d;
  logic [LZW-1:0]      lzc_q, lzc_d;
  logic [MANTISSA-1:0] normm_q, normm_d;
  logic [EW-1:0]       norme_q, norme_d;
  logic                zero_q, zero_d, nege_q, nege_d, ovf_q, ovf_d;
  logic                fg_q, fg_d, r_q, r_d, s_q, s_d;
  logic                carry, zero;
  logic [SW-3:0]       sh;
  logic [EW-1:0]       ce;

  always_comb begin
    sum_d  = ld1 ? sum_i  : sum_q;
    cexp_d = ld1 ? cexp_i : cexp_q;
    lzc_d  = lzc_q;
    if (ld1) begin
      // highest set bit below the carry wins; all-zero gives SW-1
      lzc_d = LZW'(SW-1);
      for (int i = 0; i < SW-1; i++)
        if (sum_i[i]) lzc_d = LZW'(SW-2-i);
    end
  end

  always_comb begin
    carry = sum_q[SW-1];
    zero  = ~|sum_q;
    ce    = EW'(cexp_q);
    // only bits below the hidden-bit slot are ever observed after the shift
    sh    = carry ? sum_q[SW-2:1] : (sum_q[SW-3:0] << lzc_q);
    normm_d = normm_q; norme_d = norme_q; zero_d = zero_q; nege_d = nege_q;
    ovf_d   = ovf_q;   fg_d    = fg_q;    r_d    = r_q;    s_d    = s_q;
    if (ld2) begin
      normm_d = '0; norme_d = '0; zero_d = zero; nege_d = 1'b0;
      ovf_d   = 1'b0; fg_d = 1'b0; r_d = 1'b0; s_d = 1'b0;
      if (!zero) begin
        normm_d = sh[SW-3 -: MANTISSA];
        fg_d    = sh[EXPONENT-1];
        r_d     = sh[EXPONENT-2];
        s_d     = (|sh[EXPONENT-3:0]) | (carry & sum_q[0]);
        norme_d = carry ? ce + EW'(1) : ce - EW'(lzc_q);
        nege_d  = ~carry & (32'(lzc_q) > 32'(cexp_q));
        ovf_d   = carry & ((ce + EW'(1)) >= EW'((1 << EXPONENT) - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q <= '0; cexp_q <= '0; lzc_q <= '0;
      normm_q <= '0; norme_q <= '0; zero_q <= 1'b0; nege_q <= 1'b0;
      ovf_q <= 1'b0; fg_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0;
    end else begin
      sum_q <= sum_d; cexp_q <= cexp_d; lzc_q <= lzc_d;
      normm_q <= normm_d; norme_q <= norme_d; zero_q <= zero_d; nege_q <= nege_d;
      ovf_q <= ovf_d; fg_q <= fg_d; r_q <= r_d; s_q <= s_d;
    end
  end

  assign normm_o = normm_q;
  assign norme_o = norme_q;
  assign zero_o  = zero_q;
  assign nege_o  = nege_q;
  assign ovf_o   = ovf_q;
  assign fg_o    = fg_q;
  assign r_o     = r_q;
  assign s_o     = s_q;
endmodule

module fp_normalize_pipe #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10,
  parameter int LANES    = 1,
  parameter int TAG_W    = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  fp_normalize_pipe_if.slave bus
);
  localparam int SW = MANTISSA + EXPONENT + 2;

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic             adv1, adv2, ld1, ld2;

  logic [LANES-1:0][MANTISSA-1:0] normm;
  logic [LANES-1:0][EXPONENT:0]   norme;
  logic [LANES-1:0]               zero, nege, ovf, fg, r, s;

  always_comb begin
    adv2   = ~v2_q | bus.out_ready;
    adv1   = ~v1_q | adv2;
    ld1    = adv1 & bus.in_valid & ~flush;
    ld2    = adv2 & v1_q & ~flush;
    v1_d   = flush ? 1'b0 : (adv1 ? bus.in_valid : v1_q);
    v2_d   = flush ? 1'b0 : (adv2 ? v1_q : v2_q);
    tag1_d = ld1 ? bus.in_tag : tag1_q;
    tag2_d = ld2 ? tag1_q : tag2_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1_q <= 1'b0; v2_q <= 1'b0; tag1_q <= '0; tag2_q <= '0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; tag1_q <= tag1_d; tag2_q <= tag2_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_normalize_lane #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA), .SW(SW)) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .ld1     (ld1),
      .ld2     (ld2),
      .sum_i   (bus.in_sum[g*SW +: SW]),
      .cexp_i  (bus.in_cexp[g*EXPONENT +: EXPONENT]),
      .normm_o (normm[g]),
      .norme_o (norme[g]),
      .zero_o  (zero[g]),
      .nege_o  (nege[g]),
      .ovf_o   (ovf[g]),
      .fg_o    (fg[g]),
      .r_o     (r[g]),
      .s_o     (s[g])
    );
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2_q;
  assign bus.out_tag   = tag2_q;
  assign bus.out_normm = normm;
  assign bus.out_norme = norme;
  assign bus.out_zero  = zero;
  assign bus.out_nege  = nege;
  assign bus.out_ovf   = ovf;
  assign bus.out_fg    = fg;
  assign bus.out_r     = r;
  assign bus.out_s     = s;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe: directed vectors push expected
// results; a negedge monitor pops and compares every delivered beat.
module tb_fp_normalize_pipe;
  localparam int EXPONENT = 5, MANTISSA = 10, LANES = 1, TAG_W = 4;

  typedef struct packed {
    logic [3:0] tag;
    logic [9:0] normm;
    logic [5:0] norme;
    logic       zero, nege, ovf, fg, r, s;
  } res_t;

  logic clk = 1'b0, resetn, flush;
  int   n_chk = 0, n_pass = 0;
  res_t q[$];
  res_t held, act, e;
  logic held_v = 1'b0;

  fp_normalize_pipe_if #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA), .LANES(LANES), .TAG_W(TAG_W)) bus();
  fp_normalize_pipe #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic [3:0] t, input logic [9:0] m, input logic [5:0] x,
                              input logic z, input logic n, input logic o,
                              input logic f, input logic rr, input logic ss);
    return {t, m, x, z, n, o, f, rr, ss};
  endfunction

  function automatic res_t cur();
    return {bus.out_tag, bus.out_normm, bus.out_norme, bus.out_zero, bus.out_nege,
            bus.out_ovf, bus.out_fg, bus.out_r, bus.out_s};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (!resetn) held_v = 1'b0;
    else begin
      act = cur();
      if (held_v && bus.out_valid) chk("hold_stable", act, held);
      held_v = bus.out_valid && !bus.out_ready;
      held   = act;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %h expected none", act);
        end else begin
          e = q.pop_front();
          chk($sformatf("beat_tag%0d", e.tag), act, e);
        end
      end
    end
  end

  task automatic send(input logic [16:0] s, input logic [4:0] c, input res_t ex);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.in_sum = s; bus.in_cexp = c; bus.in_tag = ex.tag;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        if (!flush) q.push_back(ex);
      end
    end
    if (!ok) begin n_chk++; $display("FAIL accept_timeout: got in_ready=0 expected 1"); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin @(negedge clk); k++; end
    if (q.size() != 0) begin n_chk++; $display("FAIL drain_timeout: got %0d pending expected 0", q.size()); end
    @(posedge clk); #1;
  endtask

  logic [16:0] vs[8];
  logic [4:0]  vc[8];
  res_t        ve[8];

  initial begin
    vs[0] = 17'h10003; vc[0] = 5'd15; ve[0] = mk(1, 10'h000, 6'd16, 0, 0, 0, 0, 0, 1);
    vs[1] = 17'h00401; vc[1] = 5'd15; ve[1] = mk(2, 10'h001, 6'd10, 0, 0, 0, 0, 0, 0);
    vs[2] = 17'h00000; vc[2] = 5'd20; ve[2] = mk(3, 10'h000, 6'd0,  1, 0, 0, 0, 0, 0);
    vs[3] = 17'h00001; vc[3] = 5'd3;  ve[3] = mk(4, 10'h000, 6'h34, 0, 1, 0, 0, 0, 0);
    vs[4] = 17'h10000; vc[4] = 5'd31; ve[4] = mk(5, 10'h000, 6'd32, 0, 0, 1, 0, 0, 0);
    vs[5] = 17'h0ABCD; vc[5] = 5'd10; ve[5] = mk(6, 10'h15E, 6'd10, 0, 0, 0, 0, 1, 1);
    vs[6] = 17'h1FFFE; vc[6] = 5'd30; ve[6] = mk(7, 10'h3FF, 6'd31, 0, 0, 1, 1, 1, 1);
    vs[7] = 17'h00300; vc[7] = 5'd2;  ve[7] = mk(8, 10'h200, 6'h3C, 0, 1, 0, 0, 0, 0);

    resetn = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_cexp = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_outputs", cur(), 32'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // latency: accepted at one edge, visible after the next
    send(vs[0], vc[0], ve[0]);
    chk("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    drain();

    for (int i = 1; i < 8; i++) send(vs[i], vc[i], ve[i]);
    drain();

    // stall: out_ready low while four beats stream in
    bus.out_ready = 1'b0;
    fork
      begin
        res_t t;
        t = ve[1]; t.tag = 4'd1; send(vs[1], vc[1], t);
        t = ve[5]; t.tag = 4'd2; send(vs[5], vc[5], t);
        t = ve[7]; t.tag = 4'd3; send(vs[7], vc[7], t);
        t = ve[6]; t.tag = 4'd4; send(vs[6], vc[6], t);
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // flush with both stages occupied
    bus.out_ready = 1'b0;
    send(vs[0], vc[0], ve[0]);
    send(vs[1], vc[1], ve[1]);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    // a beat offered alongside flush must vanish too
    bus.in_valid = 1'b1; bus.in_sum = vs[2]; bus.in_cexp = vc[2]; bus.in_tag = 4'hF;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_idle_valid", 32'(bus.out_valid), 32'd0);

    // asynchronous reset with two beats in flight
    bus.out_ready = 1'b0;
    send(vs[3], vc[3], ve[3]);
    send(vs[4], vc[4], ve[4]);
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outputs", cur(), 32'd0);
    q.delete();
    @(negedge clk) resetn = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    send(vs[5], vc[5], ve[5]);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
